// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encoding, FSM states and width for the shift sequencer
package shift_pkg;

  localparam int WIDTH = 16;

  // Same encoding the ALU control emits as func for shift opcodes
  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-step shift/rotate; 4-position step when SHIFT_SEQ_FAST4_EN is defined
module shift_step
  import shift_pkg::*;
#(
  parameter int W = shift_pkg::WIDTH
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] data,
`ifdef SHIFT_SEQ_FAST4_EN
  output logic [W-1:0] shift4,
`endif
  output logic [W-1:0] shift1
);

  always_comb begin
    shift1 = data;
    case (op)
      OP_ROL:  shift1 = {data[W-2:0], data[W-1]};
      OP_SLL:  shift1 = {data[W-2:0], 1'b0};
      OP_ROR:  shift1 = {data[0], data[W-1:1]};
      default: shift1 = {1'b0, data[W-1:1]};
    endcase
  end

`ifdef SHIFT_SEQ_FAST4_EN
  always_comb begin
    shift4 = data;
    case (op)
      OP_ROL:  shift4 = {data[W-5:0], data[W-1:W-4]};
      OP_SLL:  shift4 = {data[W-5:0], 4'b0000};
      OP_ROR:  shift4 = {data[3:0], data[W-1:4]};
      default: shift4 = {4'b0000, data[W-1:4]};
    endcase
  end
`endif

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - iterative shift/rotate sequencer with start/busy/done handshake; SHIFT_SEQ_FAST4_EN enables 4-position steps
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [3:0]       shamt,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  logic [3:0]       cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] step1;
  logic [WIDTH-1:0] step_val;
  logic [3:0]       cnt_nxt;

`ifdef SHIFT_SEQ_FAST4_EN
  logic [WIDTH-1:0] step4;

  shift_step #(.W(WIDTH)) u_step (
    .op     (op_q),
    .data   (result),
    .shift4 (step4),
    .shift1 (step1)
  );
`else
  shift_step #(.W(WIDTH)) u_step (
    .op     (op_q),
    .data   (result),
    .shift1 (step1)
  );
`endif

  // cnt is always >= 1 while in SHIFT, so neither subtraction can wrap
  always_comb begin
    step_val = step1;
    cnt_nxt  = cnt - 4'd1;
`ifdef SHIFT_SEQ_FAST4_EN
    if (cnt >= 4'd4) begin
      step_val = step4;
      cnt_nxt  = cnt - 4'd4;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= 4'd0;
      op_q   <= OP_ROL;
    end else begin
      case (state)
        ST_SHIFT: begin
          result <= step_val;
          cnt    <= cnt_nxt;
          if (cnt_nxt == 4'd0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        // IDLE and DONE both accept a command; DONE acceptance gives back-to-back
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            result <= in_data;
            cnt    <= shamt;
            op_q   <= op;
            if (shamt != 4'd0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - self-checking bench for shift_seq; honours SHIFT_SEQ_FAST4_EN for expected latency
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  shamt = 4'd0;
  logic [15:0] in_data = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail = 0;

  shift_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .in_data (in_data),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model(input logic [1:0] m_op, input int n, input logic [15:0] x);
    int xi;
    int v;
    xi = int'(x);
    case (m_op)
      2'b00:   v = (xi << n) | (xi >> (16 - n));
      2'b01:   v = xi << n;
      2'b10:   v = (xi >> n) | (xi << (16 - n));
      default: v = xi >> n;
    endcase
    return v[15:0];
  endfunction

  // Cycles from the accepting edge until done is observed
  function automatic int exp_lat(input int n);
`ifdef SHIFT_SEQ_FAST4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    op      = 2'($urandom_range(3));
    shamt   = 4'($urandom_range(15));
    in_data = 16'($urandom_range(16'hFFFF));
  endtask

  // Drives one command and measures the response; the caller does the checking
  task automatic issue(input logic [1:0] c_op, input int n, input logic [15:0] x,
                       output int done_cyc, output int busy_cnt,
                       output logic [15:0] res, output logic done_next);
    start = 1'b1; op = c_op; shamt = 4'(n); in_data = x;
    tick();
    start = 1'b0;
    scramble_inputs();
    done_cyc = -1; busy_cnt = 0; res = 16'hxxxx; done_next = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        res = result;
        break;
      end
      tick();
    end
    if (done_cyc > 0) begin
      tick();
      done_next = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h want 0 0 0000", busy, done, result);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, result} !== 18'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b done=%b result=%h want 0 0 0000", busy, done, result);
    end
  endtask

  typedef struct {
    logic [1:0]  c_op;
    int          n;
    logic [15:0] x;
    logic [15:0] want;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[7];
    int dc, bc;
    logic [15:0] r;
    logic dn;
    vecs[0] = '{2'b01, 15, 16'h0001, 16'h8000};
    vecs[1] = '{2'b00, 4,  16'h1234, 16'h2341};
    vecs[2] = '{2'b10, 1,  16'h0001, 16'h8000};
    vecs[3] = '{2'b11, 4,  16'h8000, 16'h0800};
    vecs[4] = '{2'b11, 15, 16'hFFFF, 16'h0001};
    vecs[5] = '{2'b10, 0,  16'hA5A5, 16'hA5A5};
    vecs[6] = '{2'b00, 0,  16'h5A3C, 16'h5A3C};
    foreach (vecs[i]) begin
      issue(vecs[i].c_op, vecs[i].n, vecs[i].x, dc, bc, r, dn);
      n_checks++;
      if (r !== vecs[i].want) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, r, vecs[i].want);
      end
      n_checks++;
      if (dc !== exp_lat(vecs[i].n)) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, dc, exp_lat(vecs[i].n));
      end
      n_checks++;
      if (bc !== exp_lat(vecs[i].n) - 1) begin
        n_fail++;
        $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, bc, exp_lat(vecs[i].n) - 1);
      end
      n_checks++;
      if (dn !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_done_width[%0d]: got done=%b after pulse want 0", i, dn);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int dc;
    start = 1'b1; op = 2'b01; shamt = 4'd8; in_data = 16'h00FF;
    tick();
    start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      // A start during busy carrying different operands must be dropped
      if (c == 2) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ignore_busy_state: got busy=%b want 1", busy);
        end
        start = 1'b1; op = 2'b11; shamt = 4'd3; in_data = 16'hBEEF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (result !== 16'hFF00) begin
      n_fail++;
      $display("FAIL ignore_busy_result: got %h want ff00", result);
    end
    n_checks++;
    if (dc !== exp_lat(8)) begin
      n_fail++;
      $display("FAIL ignore_busy_latency: got %0d want %0d", dc, exp_lat(8));
    end
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_busy_no_requeue: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    logic [15:0] r;
    logic dn;
    start = 1'b1; op = 2'b01; shamt = 4'd8; in_data = 16'h00FF;
    tick();
    start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      tick();
    end
    n_checks++;
    if (dc !== exp_lat(8) || result !== 16'hFF00) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d result=%h want lat=%0d result=ff00", dc, result, exp_lat(8));
    end
    // Start presented in the DONE cycle
    start = 1'b1; op = 2'b11; shamt = 4'd8; in_data = 16'hFF00;
    tick();
    start = 1'b0;
    scramble_inputs();
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_no_gap: got busy=%b done=%b want 1 0", busy, done);
    end
    dc = -1; bc = 0; dn = 1'b0; r = 16'h0000;
    for (int c = 1; c <= 40; c++) begin
      if (busy) bc++;
      if (done) begin
        dc = c;
        r = result;
        break;
      end
      tick();
    end
    n_checks++;
    if (r !== 16'h00FF || dc !== exp_lat(8)) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d result=%h want lat=%0d result=00ff", dc, r, exp_lat(8));
    end
    tick();
  endtask

  task automatic test_async_reset();
    int dc, bc, pulses;
    logic [15:0] r;
    logic dn;
`ifdef SHIFT_SEQ_FAST4_EN
    int rst_cyc = 2;
`else
    int rst_cyc = 5;
`endif
    start = 1'b1; op = 2'b01; shamt = 4'd10; in_data = 16'h0001;
    tick();
    start = 1'b0;
    for (int c = 1; c < rst_cyc; c++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_precondition: got busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, result} !== 18'h0) begin
      n_fail++;
      $display("FAIL areset_async: got busy=%b done=%b result=%h want 0 0 0000", busy, done, result);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL areset_no_done: got %0d done pulses want 0", pulses);
    end
    issue(2'b00, 3, 16'h8001, dc, bc, r, dn);
    n_checks++;
    if (r !== 16'h000C || dc !== exp_lat(3)) begin
      n_fail++;
      $display("FAIL areset_recover: got lat=%0d result=%h want lat=%0d result=000c", dc, r, exp_lat(3));
    end
  endtask

  task automatic test_random();
    int dc, bc, n;
    logic [1:0] c_op;
    logic [15:0] x, r, want;
    logic dn;
    for (int i = 0; i < 60; i++) begin
      c_op = 2'($urandom_range(3));
      n    = $urandom_range(15);
      x    = 16'($urandom_range(16'hFFFF));
      want = model(c_op, n, x);
      issue(c_op, n, x, dc, bc, r, dn);
      n_checks++;
      if (r !== want) begin
        n_fail++;
        $display("FAIL random_result[%0d] op=%0d n=%0d x=%h: got %h want %h", i, c_op, n, x, r, want);
      end
      n_checks++;
      if (dc !== exp_lat(n) || bc !== exp_lat(n) - 1 || dn !== 1'b0) begin
        n_fail++;
        $display("FAIL random_timing[%0d] n=%0d: got lat=%0d busy=%0d done_next=%b want lat=%0d busy=%0d done_next=0",
                 i, n, dc, bc, dn, exp_lat(n), exp_lat(n) - 1);
      end
      repeat ($urandom_range(2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Iterative shift/rotate sequencer for the 16-bit execute stage. It accepts one shift or rotate command (ROL, SLL, ROR, SRL) with a 4-bit shift amount and performs it one bit position per cycle on an internal register. It reports progress with a start/busy/done handshake. The decode stage sends it the same `func` encoding and `shamt` that the ALU control already produces for shift opcodes, so a multi-cycle shifter can replace the barrel shifter.

## Interface

Parameters:
- `WIDTH`, 16, data width (must be 16; the 4-bit shamt covers 0..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only when `busy`=0.
- `op`  in  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- `shamt`  in  4  shift amount, 0..15.
- `in_data`  in  WIDTH  operand.
- `busy`  out  1  high while a command is in progress.
- `done`  out  1  one-cycle pulse; `result` is final.
- `result`  out  WIDTH  working/final register; holds the last result until the next accepted start.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0, latched op=00.
- IDLE or DONE with `start`=1 (command accepted):
  - `result`<=`in_data`, cnt<=`shamt`, op latched.
  - Next state is SHIFT if `shamt`≠0, else DONE.
- SHIFT: each cycle applies one step to `result` and decrements cnt.
  - ROL: {r[14:0],r[15]}
  - SLL: {r[14:0],0}
  - ROR: {r[0],r[15:1]}
  - SRL: {0,r[15:1]}
  - The cycle whose step brings cnt to 0 moves to DONE.
- DONE: `done`=1 for exactly this cycle.
  - Next state is IDLE, unless `start`=1, which is accepted in the same cycle (back-to-back).
- `busy`=1 in SHIFT only. `start` while `busy`=1 is ignored; there is no queueing.
- `op`, `shamt` and `in_data` are used only at acceptance. Later changes have no effect.
- Counter arithmetic is 4-bit unsigned and never decrements below 0. A rotate by 0 and a shift by 0 both return the operand unchanged.
- Async reset mid-operation aborts the command immediately: all outputs take their reset values and no `done` is issued.

## Timing

- `start` accepted at edge k with shamt N≠0:
  - `busy` is high for cycles k+1..k+N.
  - `done` is high at cycle k+N+1.
  - Total latency is N+1 cycles.
- shamt 0: `done` is high at cycle k+1, with no `busy` cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back: a start in the DONE cycle produces SHIFT (or DONE) on the next edge, with no IDLE gap.

## Configuration

- Macro `SHIFT_SEQ_FAST4_EN`.
- Defined: in SHIFT, a cycle with cnt≥4 applies a 4-position step and subtracts 4; otherwise it applies a 1-position step.
  - Step count is N/4 + N%4, and latency is that count plus 1.
  - Example: shamt 15 → 3+3 = 6 steps, `done` at k+7.
- Undefined: single-bit steps only, with latency N+1 as above.
- Result values are identical in both builds; only the cycle counts differ.

## Structure

- Shared package `shift_pkg`:
  - op encoding constants `OP_ROL`/`OP_SLL`/`OP_ROR`/`OP_SRL` (matching the ALU func encoding).
  - FSM state enum.
  - `WIDTH` constant.
- Sub-module `shift_step`: combinational shift by 1 (and by 4 when `SHIFT_SEQ_FAST4_EN` is defined) of a WIDTH word per op. The sequencer holds the FSM, counter and result register.

## Test plan

- SLL, in 0x0001, shamt 15 → `busy` 15 cycles; `done` at k+16; result 0x8000 (fast build: `done` at k+7).
- ROL 0x1234 by 4 → 0x2341. ROR 0x0001 by 1 → 0x8000, with `done` at k+2.
- SRL 0x8000 by 4 → 0x0800. SRL 0xFFFF by 15 → 0x0001.
- shamt 0, op ROR, in 0xA5A5 → no `busy`; `done` at k+1; result 0xA5A5.
- SLL 0x00FF by 8 with `start` pulsed again at cycle k+3 carrying other operands → second start ignored; result 0xFF00. A start in the DONE cycle with SRL 0xFF00 by 8 → 0x00FF, with no idle gap.
- `rst_n` low at cycle k+5 of a 10-step command → `busy`=0, `done`=0, `result`=0 asynchronously, with no `done` pulse after release. A new command after release completes normally.
